ysyx_23060184_rd_arbiter: RTL and testbench

YSYX_23060184_RD_ARBITER -- requirements
Module: ysyx_23060184_rd_arbiter

---
 rtl/ysyx_23060184_rd_arbiter_pkg.sv | 23 ++
 rtl/ysyx_23060184_arb_timer.sv | 38 +++
 rtl/ysyx_23060184_rd_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ysyx_23060184_rd_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060184_rd_arbiter_pkg.sv
// Shared widths, AXI read response codes and FSM encodings for the two-master read arbiter.
package ysyx_23060184_rd_arbiter_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ACERR_WIDTH = 2;
    localparam int TMR_WIDTH   = 16;

    localparam logic [ACERR_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [ACERR_WIDTH-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_AR   = 2'b01,
        ST_R    = 2'b10,
        ST_ERR  = 2'b11
    } arb_state_e;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/ysyx_23060184_arb_timer.sv
// R-phase watchdog: counts stalled R cycles and flags the cycle that reaches TIMEOUT_CYC.
module ysyx_23060184_arb_timer
    import ysyx_23060184_rd_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TMR_WIDTH-1:0] LAST_CNT = TMR_WIDTH'(TIMEOUT_CYC - 1);

    logic [TMR_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + TMR_WIDTH'(1);
        end
    end

    // Fires during the TIMEOUT_CYC-th stalled cycle so ERR follows on that edge.
    assign expired_o = enable_i && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_23060184_rd_arbiter.sv
// IFU/LSU read arbiter onto one SRAM port with R-phase timeout.
// Define YSYX_23060184_ARB_RR_EN for round-robin ties; otherwise the LSU (m1) always wins.
module ysyx_23060184_rd_arbiter
    import ysyx_23060184_rd_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  m0_araddr,
    input  logic                   m0_arvalid,
    output logic                   m0_arready,
    output logic [DATA_WIDTH-1:0]  m0_rdata,
    output logic [ACERR_WIDTH-1:0] m0_rresp,
    output logic                   m0_rvalid,
    input  logic                   m0_rready,
    input  logic [DATA_WIDTH-1:0]  m1_araddr,
    input  logic                   m1_arvalid,
    output logic                   m1_arready,
    output logic [DATA_WIDTH-1:0]  m1_rdata,
    output logic [ACERR_WIDTH-1:0] m1_rresp,
    output logic                   m1_rvalid,
    input  logic                   m1_rready,
    output logic [DATA_WIDTH-1:0]  s_araddr,
    output logic                   s_arvalid,
    input  logic                   s_arready,
    input  logic [DATA_WIDTH-1:0]  s_rdata,
    input  logic [ACERR_WIDTH-1:0] s_rresp,
    input  logic                   s_rvalid,
    output logic                   s_rready
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    arb_owner_e grant;

    logic                  own_arvalid;
    logic [DATA_WIDTH-1:0] own_araddr;
    logic                  own_rready;
    logic                  tmr_clr, tmr_en, tmr_exp;

    assign own_arvalid = (owner_q == OWN_M1) ? m1_arvalid : m0_arvalid;
    assign own_araddr  = (owner_q == OWN_M1) ? m1_araddr  : m0_araddr;
    assign own_rready  = (owner_q == OWN_M1) ? m1_rready  : m0_rready;

`ifdef YSYX_23060184_ARB_RR_EN
    arb_owner_e last_q, last_d;

    always_comb begin
        if (m0_arvalid && m1_arvalid) begin
            grant = (last_q == OWN_M0) ? OWN_M1 : OWN_M0;
        end else begin
            grant = m1_arvalid ? OWN_M1 : OWN_M0;
        end
    end

    assign last_d = ((state_q == ST_IDLE) && (m0_arvalid || m1_arvalid)) ? grant : last_q;

    // Reset to m1 so the first tie after reset goes to m0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= OWN_M1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign grant = m1_arvalid ? OWN_M1 : OWN_M0;
`endif

    ysyx_23060184_arb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmr_clr),
        .enable_i  (tmr_en),
        .expired_o (tmr_exp)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = RESP_OKAY;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = RESP_OKAY;
        m1_rvalid  = 1'b0;
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Drain any stale SRAM beat while nobody owns the bus.
                s_rready = 1'b1;
                if (m0_arvalid || m1_arvalid) begin
                    state_d = ST_AR;
                    owner_d = grant;
                end
            end
            ST_AR: begin
                s_arvalid = own_arvalid;
                s_araddr  = own_araddr;
                if (owner_q == OWN_M1) begin
                    m1_arready = s_arready;
                end else begin
                    m0_arready = s_arready;
                end
                if (own_arvalid && s_arready) begin
                    state_d = ST_R;
                    tmr_clr = 1'b1;
                end
            end
            ST_R: begin
                s_rready = own_rready;
                if (owner_q == OWN_M1) begin
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rvalid = s_rvalid;
                end else begin
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rvalid = s_rvalid;
                end
                // A handshake in the expiry cycle takes precedence over the timeout.
                if (s_rvalid && own_rready) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_exp) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                s_rready = 1'b1;
                if (owner_q == OWN_M1) begin
                    m1_rvalid = 1'b1;
                    m1_rresp  = RESP_SLVERR;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rresp  = RESP_SLVERR;
                end
                if (own_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_M0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_rd_arbiter.sv
// Directed self-checking bench for the read arbiter (TIMEOUT_CYC = 4).
module tb_ysyx_23060184_rd_arbiter;
    import ysyx_23060184_rd_arbiter_pkg::*;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h8000_1000;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [DATA_WIDTH-1:0]  m0_araddr, m1_araddr, s_araddr, s_rdata, m0_rdata, m1_rdata;
    logic                   m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic                   m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [ACERR_WIDTH-1:0] m0_rresp, m1_rresp, s_rresp;
    logic                   s_arvalid, s_arready, s_rvalid, s_rready;

    int n_assert = 0;
    int n_fail   = 0;
    bit first;

    always #5 clk = ~clk;

    ysyx_23060184_rd_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_araddr  (m0_araddr),
        .m0_arvalid (m0_arvalid),
        .m0_arready (m0_arready),
        .m0_rdata   (m0_rdata),
        .m0_rresp   (m0_rresp),
        .m0_rvalid  (m0_rvalid),
        .m0_rready  (m0_rready),
        .m1_araddr  (m1_araddr),
        .m1_arvalid (m1_arvalid),
        .m1_arready (m1_arready),
        .m1_rdata   (m1_rdata),
        .m1_rresp   (m1_rresp),
        .m1_rvalid  (m1_rvalid),
        .m1_rready  (m1_rready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered with the arbiter in AR for `own`; runs AR and R handshakes and returns in IDLE.
    task automatic do_txn(input bit own, input logic [31:0] data, input bit keep);
        s_arready = 1'b1;
        #1;
        chk("ar_valid", 32'(s_arvalid), 32'd1);
        chk("ar_addr", s_araddr, own ? A1 : A0);
        chk("ar_ready_own", 32'(own ? m1_arready : m0_arready), 32'd1);
        chk("ar_ready_oth", 32'(own ? m0_arready : m1_arready), 32'd0);
        tick;
        s_arready = 1'b0;
        if (!keep) begin
            if (own) m1_arvalid = 1'b0;
            else     m0_arvalid = 1'b0;
        end
        s_rvalid = 1'b1;
        s_rdata  = data;
        s_rresp  = RESP_OKAY;
        #1;
        chk("r_valid_own", 32'(own ? m1_rvalid : m0_rvalid), 32'd1);
        chk("r_data_own", own ? m1_rdata : m0_rdata, data);
        chk("r_resp_own", 32'(own ? m1_rresp : m0_rresp), 32'(RESP_OKAY));
        chk("r_valid_oth", 32'(own ? m0_rvalid : m1_rvalid), 32'd0);
        chk("r_data_oth", own ? m0_rdata : m1_rdata, 32'd0);
        tick;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        #1;
        chk("idle_no_ar", 32'(s_arvalid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        m0_araddr = A0; m1_araddr = A1;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_rready = 1'b1; m1_rready = 1'b1;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = RESP_OKAY;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_arvalid", 32'(s_arvalid), 32'd0);
        chk("rst_m0_arready", 32'(m0_arready), 32'd0);
        chk("rst_m1_arready", 32'(m1_arready), 32'd0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_s_rready", 32'(s_rready), 32'd1);
        reset = 1'b0;

        // Single IFU fetch: one-cycle grant latency.
        m0_arvalid = 1'b1;
        #1;
        chk("grant_latency", 32'(s_arvalid), 32'd0);
        tick;
        do_txn(1'b0, 32'h0000_0413, 1'b0);

        // Tie, winner keeps requesting so a second tie follows.
`ifdef YSYX_23060184_ARB_RR_EN
        first = 1'b0;
`else
        first = 1'b1;
`endif
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        tick;
        do_txn(first, 32'h1111_1111, 1'b1);
        tick;
        do_txn(1'b1, 32'h2222_2222, 1'b0);
        tick;
        do_txn(1'b0, 32'h3333_3333, 1'b0);

        // m1 requests while m0 sits in R.
        m0_arvalid = 1'b1;
        tick;
        s_arready = 1'b1;
        #1;
        tick;
        s_arready = 1'b0;
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b1;
        #1;
        chk("busy_m1_ar_0", 32'(m1_arready), 32'd0);
        chk("busy_m0_rvalid", 32'(m0_rvalid), 32'd0);
        tick;
        chk("busy_m1_ar_1", 32'(m1_arready), 32'd0);
        s_rvalid = 1'b1;
        s_rdata  = 32'h4444_4444;
        #1;
        chk("busy_m0_rdata", m0_rdata, 32'h4444_4444);
        tick;
        s_rvalid = 1'b0;
        #1;
        chk("busy_idle_ar", 32'(m1_arready), 32'd0);
        chk("busy_idle_sv", 32'(s_arvalid), 32'd0);
        tick;
        do_txn(1'b1, 32'h5555_5555, 1'b0);

        // Timeout: SRAM silent for 4 R cycles.
        m0_arvalid = 1'b1;
        tick;
        s_arready = 1'b1;
        #1;
        tick;
        s_arready = 1'b0;
        m0_arvalid = 1'b0;
        m0_rready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("to_r_rvalid", 32'(m0_rvalid), 32'd0);
            chk("to_r_srready", 32'(s_rready), 32'd0);
            tick;
        end
        chk("err_rvalid", 32'(m0_rvalid), 32'd1);
        chk("err_rresp", 32'(m0_rresp), 32'(RESP_SLVERR));
        chk("err_rdata", m0_rdata, 32'd0);
        chk("err_s_rready", 32'(s_rready), 32'd1);
        chk("err_s_arvalid", 32'(s_arvalid), 32'd0);
        chk("err_m1_rvalid", 32'(m1_rvalid), 32'd0);
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("late_not_fwd", m0_rdata, 32'd0);
        chk("late_resp", 32'(m0_rresp), 32'(RESP_SLVERR));
        tick;
        chk("err_hold", 32'(m0_rvalid), 32'd1);
        m0_rready = 1'b1;
        tick;
        chk("drain_s_rready", 32'(s_rready), 32'd1);
        chk("drain_m0_rvalid", 32'(m0_rvalid), 32'd0);
        s_rvalid = 1'b0;

        // Data arrives in the expiry cycle: handshake wins.
        m1_arvalid = 1'b1;
        tick;
        s_arready = 1'b1;
        #1;
        tick;
        s_arready = 1'b0;
        m1_arvalid = 1'b0;
        repeat (3) tick;
        s_rvalid = 1'b1;
        s_rdata  = 32'h6666_6666;
        #1;
        chk("tie_rvalid", 32'(m1_rvalid), 32'd1);
        chk("tie_rdata", m1_rdata, 32'h6666_6666);
        chk("tie_rresp", 32'(m1_rresp), 32'(RESP_OKAY));
        tick;
        s_rvalid = 1'b0;
        #1;
        chk("tie_no_err", 32'(m1_rvalid), 32'd0);

        // Asynchronous reset while in R.
        m0_arvalid = 1'b1;
        tick;
        s_arready = 1'b1;
        #1;
        tick;
        s_arready = 1'b0;
        m0_arvalid = 1'b0;
        m0_rready = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = 32'h7777_7777;
        #1;
        chk("pre_rst_rvalid", 32'(m0_rvalid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_rvalid", 32'(m0_rvalid), 32'd0);
        chk("arst_rdata", m0_rdata, 32'd0);
        chk("arst_s_arvalid", 32'(s_arvalid), 32'd0);
        chk("arst_m0_arready", 32'(m0_arready), 32'd0);
        s_rvalid = 1'b0;
        s_rdata  = '0;
        tick;
        reset = 1'b0;
        m0_rready = 1'b1;

        // First tie after reset.
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        tick;
        do_txn(first, 32'h8888_8888, 1'b0);
        tick;
        do_txn(!first, 32'h9999_9999, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
